// File: rtl/grid_io_multi_top_if.sv
// Pad-side and fabric-side signal bundle for grid_io_multi_top.
// Master is the surrounding fabric or bench; slave is the I/O tile.
interface grid_io_multi_top_if #(
  parameter int NUM_IO = 4
);
  logic              ccff_en;
  logic              ccff_head;
  logic              ccff_tail;
  logic              cfg_done;
  logic [NUM_IO-1:0] io_outpad;
  logic [NUM_IO-1:0] io_inpad;
  logic [NUM_IO-1:0] gfpga_pad_GPIO_A;
  logic [NUM_IO-1:0] gfpga_pad_GPIO_OE;
  logic [NUM_IO-1:0] gfpga_pad_GPIO_IE;

  modport master (
    output ccff_en, ccff_head, io_outpad,
    input  ccff_tail, cfg_done, io_inpad,
           gfpga_pad_GPIO_A, gfpga_pad_GPIO_OE, gfpga_pad_GPIO_IE
  );

  modport slave (
    input  ccff_en, ccff_head, io_outpad,
    output ccff_tail, cfg_done, io_inpad,
           gfpga_pad_GPIO_A, gfpga_pad_GPIO_OE, gfpga_pad_GPIO_IE
  );
endinterface

// File: rtl/grid_io_multi_top.sv
// Multi-channel perimeter GPIO tile. A serial configuration chain is
// shifted in; a bit-counting controller copies it into a shadow register
// only once a full load has arrived, so pad controls never see partial
// configuration. Each channel has OE, IE and registered-input select.
module grid_io_multi_top #(
  parameter int NUM_IO          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int CFG_BITS_PER_IO = 3
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  inout  wire  [NUM_IO-1:0] gfpga_pad_GPIO_Y,
  grid_io_multi_top_if.slave bus
);
  localparam int CFG_BITS = CFG_BITS_PER_IO * NUM_IO;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next, cnt_inc;
  logic                done_reg, done_next;
  logic                load;
  logic [CFG_BITS-1:0] chain_reg;
  logic [CFG_BITS-1:0] shadow_reg;
  logic [NUM_IO-1:0]   oe, ie, inpad;

  assign cnt_inc = cnt_reg + CNT_W'(1);

  // Serial configuration chain; the tail is the registered last bit.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      chain_reg <= '0;
    end else if (bus.ccff_en) begin
      chain_reg <= {chain_reg[CFG_BITS-2:0], bus.ccff_head};
    end
  end

  // Shadow copy takes the pre-shift chain contents in the LOAD cycle.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      shadow_reg <= '0;
    end else if (load) begin
      shadow_reg <= chain_reg;
    end
  end

  // Controller state, bit counter and done flag.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic: count shifts until a full load, then commit once.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = done_reg;
    load       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.ccff_en) begin
          state_next = SHIFT;
          cnt_next   = CNT_W'(1);
        end
      end
      SHIFT: begin
        if (bus.ccff_en) begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_W'(CFG_BITS)) begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        load = 1'b1;
        if (bus.ccff_en) begin
          // A new load starts immediately; this edge is its first bit.
          state_next = SHIFT;
          cnt_next   = CNT_W'(1);
          done_next  = 1'b0;
        end else begin
          state_next = DONE;
          done_next  = 1'b1;
        end
      end
      DONE: begin
        if (bus.ccff_en) begin
          state_next = SHIFT;
          cnt_next   = CNT_W'(1);
          done_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-channel pad control and input path.
  for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_ch
    logic                   raw;
    logic [SYNC_STAGES-1:0] sync_reg;

    assign oe[gi] = shadow_reg[3*gi];
    assign ie[gi] = shadow_reg[3*gi+1];
    assign raw    = gfpga_pad_GPIO_Y[gi] & ie[gi];

    // Input register pipeline; always clocks regardless of REG select.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
        sync_reg <= '0;
      end else begin
        sync_reg[0] <= raw;
        for (int s = 1; s < SYNC_STAGES; s++) begin
          sync_reg[s] <= sync_reg[s-1];
        end
      end
    end

    assign inpad[gi] = shadow_reg[3*gi+2] ? sync_reg[SYNC_STAGES-1] : raw;
  end

  assign bus.ccff_tail         = chain_reg[CFG_BITS-1];
  assign bus.cfg_done          = done_reg;
  assign bus.gfpga_pad_GPIO_A  = bus.io_outpad;
  assign bus.gfpga_pad_GPIO_OE = oe;
  assign bus.gfpga_pad_GPIO_IE = ie;
  assign bus.io_inpad          = inpad;
endmodule
